// File: rtl/uart_pkg.sv
// Shared UART definitions used by both the receive and transmit paths:
// frame state encoding, frame geometry and default clock/baud settings.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_e;

  localparam int DATA_BITS = 8;

  localparam int CLK_FREQ_DEF = 50_000_000;
  localparam int BAUD_LO_DEF  = 9_600;
  localparam int BAUD_HI_DEF  = 115_200;

  // Clocks per bit period, truncated the same way on the rx and tx sides.
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Request/status bundle between the Controller and the UART transmitter.
// The master side issues byte requests; the slave side serialises them.
interface uart_tx_if;

  logic [7:0] tx_data;
  logic       start;
  logic       baudselect;
  logic       tx_complete_del_flag;
  logic       tx;
  logic       busy;
  logic       tx_complete_flag;

  modport master (
    output tx_data,
    output start,
    output baudselect,
    output tx_complete_del_flag,
    input  tx,
    input  busy,
    input  tx_complete_flag
  );

  modport slave (
    input  tx_data,
    input  start,
    input  baudselect,
    input  tx_complete_del_flag,
    output tx,
    output busy,
    output tx_complete_flag
  );

endinterface

// File: rtl/uart_baud_cnt.sv
// Loadable bit-period down-counter: restart loads DIV-1 for the selected rate,
// bit_end flags the last clock of each period and the counter reloads itself.
module uart_baud_cnt #(
  parameter int DIV_LO = 5208,
  parameter int DIV_HI = 434
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en,
  input  logic restart,
  input  logic sel,
  output logic bit_end
);

  localparam int DIV_MAX = (DIV_LO > DIV_HI) ? DIV_LO : DIV_HI;
  localparam int CNT_W   = $clog2(DIV_MAX);

  localparam logic [CNT_W-1:0] LOAD_LO = CNT_W'(DIV_LO - 1);
  localparam logic [CNT_W-1:0] LOAD_HI = CNT_W'(DIV_HI - 1);

  logic [CNT_W-1:0] count;
  logic             sel_q;

  // NOTE: synchronous reset lives inside the clocked block; every state
  // register here is updated with non-blocking assignments only.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      count <= '0;
      sel_q <= 1'b0;
    end else if (restart) begin
      // The rate is captured here so a select change mid-frame is ignored.
      sel_q <= sel;
      count <= sel ? LOAD_HI : LOAD_LO;
    end else if (!en) begin
      count <= '0;
    end else if (count == '0) begin
      count <= sel_q ? LOAD_HI : LOAD_LO;
    end else begin
      count <= count - CNT_W'(1);
    end
  end

  assign bit_end = en && (count == '0);

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter: start bit, 8 data bits LSB first, stop bit.
// All outputs are registered; completion is reported through a sticky flag.
module uart_tx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ = CLK_FREQ_DEF,
  parameter int BAUD_LO  = BAUD_LO_DEF,
  parameter int BAUD_HI  = BAUD_HI_DEF
) (
  input logic     clk,
  input logic     reset_n,
  uart_tx_if.slave bus
);

  localparam int DIV_LO = calc_div(CLK_FREQ, BAUD_LO);
  localparam int DIV_HI = calc_div(CLK_FREQ, BAUD_HI);
  localparam int IDX_W  = $clog2(DATA_BITS);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);

  uart_state_e          state;
  logic [DATA_BITS-1:0] shreg;
  logic [IDX_W-1:0]     bit_idx;
  logic                 tx_q;
  logic                 busy_q;
  logic                 flag_q;

  logic accept;
  logic bit_end;

  assign accept = (state == IDLE) && bus.start;

  uart_baud_cnt #(
    .DIV_LO (DIV_LO),
    .DIV_HI (DIV_HI)
  ) u_baud_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (state != IDLE),
    .restart (accept),
    .sel     (bus.baudselect),
    .bit_end (bit_end)
  );

  // NOTE: the shift register is a handful of flops, not a memory, so it is
  // reset along with the rest of the datapath.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_idx <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      flag_q  <= 1'b0;
    end else begin
      // A completion in the same cycle overrides this clear further down.
      if (bus.tx_complete_del_flag) begin
        flag_q <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (bus.start) begin
            shreg   <= bus.tx_data;
            bit_idx <= '0;
            tx_q    <= 1'b0;
            busy_q  <= 1'b1;
            state   <= START;
          end
        end

        START: begin
          if (bit_end) begin
            tx_q    <= shreg[0];
            bit_idx <= '0;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            shreg <= {1'b0, shreg[DATA_BITS-1:1]};
            if (bit_idx == LAST_IDX) begin
              tx_q  <= 1'b1;
              state <= STOP;
            end else begin
              tx_q    <= shreg[1];
              bit_idx <= bit_idx + IDX_W'(1);
            end
          end
        end

        STOP: begin
          if (bit_end) begin
            busy_q <= 1'b0;
            flag_q <= 1'b1;
            state  <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign bus.tx               = tx_q;
  assign bus.busy             = busy_q;
  assign bus.tx_complete_flag = flag_q;

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx: table of frames with hand-built line patterns,
// plus sequences for busy-ignore, flag handshake and mid-frame reset.
module tb_uart_tx;

  localparam int DIV_HI = 434;
  localparam int DIV_LO = 5208;

  typedef struct {
    string      name;
    logic [7:0] data;
    logic       baud;
    logic [9:0] line;   // line[0] = start bit ... line[9] = stop bit
  } frame_vec_t;

  logic clk;
  logic reset_n;
  int   total;
  int   bad;

  uart_tx_if bus ();

  uart_tx dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Sends one frame and checks every cycle of it. Starts and ends on a negedge.
  // poke_at: frame cycle at which a stray start with other data/rate is pulsed.
  // del_at_end: raise the clear pulse on the very cycle the flag gets set.
  task automatic run_frame(input string name, input logic [7:0] data, input logic baud,
                           input logic [9:0] line, input int poke_at, input bit del_at_end);
    int div;
    int cyc;
    int errs;
    div = baud ? DIV_HI : DIV_LO;

    bus.tx_complete_del_flag = 1'b1;
    @(negedge clk);
    bus.tx_complete_del_flag = 1'b0;
    check({name, " flag_cleared"}, 32'(bus.tx_complete_flag), 32'd0);

    bus.tx_data    = data;
    bus.baudselect = baud;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;

    cyc = 0;
    for (int b = 0; b < 10; b++) begin
      errs = 0;
      for (int k = 0; k < div; k++) begin
        if (bus.tx !== line[b] || bus.busy !== 1'b1) errs++;
        if (cyc == poke_at) begin
          bus.start      = 1'b1;
          bus.tx_data    = 8'hFF;
          bus.baudselect = ~baud;
        end else if (cyc == poke_at + 1) begin
          bus.start = 1'b0;
        end
        if (del_at_end && cyc == 10 * div - 1) bus.tx_complete_del_flag = 1'b1;
        cyc++;
        @(negedge clk);
      end
      check($sformatf("%s bit%0d bad_cycles", name, b), 32'(errs), 32'd0);
    end

    bus.tx_complete_del_flag = 1'b0;
    check({name, " busy_end"}, 32'(bus.busy), 32'd0);
    check({name, " tx_end"}, 32'(bus.tx), 32'd1);
    check({name, " flag_end"}, 32'(bus.tx_complete_flag), 32'd1);
  endtask

  frame_vec_t vecs[3];
  int errs;

  initial begin
    total = 0;
    bad   = 0;
    reset_n                  = 1'b0;
    bus.tx_data              = 8'h00;
    bus.start                = 1'b0;
    bus.baudselect           = 1'b0;
    bus.tx_complete_del_flag = 1'b0;

    vecs[0] = '{"a5_hi", 8'hA5, 1'b1, 10'b1_10100101_0};
    vecs[1] = '{"01_hi", 8'h01, 1'b1, 10'b1_00000001_0};
    vecs[2] = '{"00_lo", 8'h00, 1'b0, 10'b1_00000000_0};

    // Reset and idle
    repeat (5) @(negedge clk);
    reset_n = 1'b1;
    errs = 0;
    for (int i = 0; i < 100; i++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0 || bus.tx_complete_flag !== 1'b0) errs++;
      @(negedge clk);
    end
    check("idle_after_reset bad_cycles", 32'(errs), 32'd0);

    // Table-driven frames
    for (int i = 0; i < 3; i++) begin
      run_frame(vecs[i].name, vecs[i].data, vecs[i].baud, vecs[i].line, -1, 1'b0);
    end

    // Stray start with different data and rate while busy
    run_frame("busy_ignore", 8'h3C, 1'b1, 10'b1_00111100_0, 2 * DIV_HI + 10, 1'b0);
    errs = 0;
    for (int i = 0; i < 2 * DIV_HI; i++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) errs++;
      @(negedge clk);
    end
    check("no_second_frame bad_cycles", 32'(errs), 32'd0);

    // Flag is sticky, then cleared by a one-cycle pulse
    errs = 0;
    for (int i = 0; i < 50; i++) begin
      if (bus.tx_complete_flag !== 1'b1) errs++;
      @(negedge clk);
    end
    check("flag_sticky bad_cycles", 32'(errs), 32'd0);
    bus.tx_complete_del_flag = 1'b1;
    @(negedge clk);
    bus.tx_complete_del_flag = 1'b0;
    check("flag_del_pulse", 32'(bus.tx_complete_flag), 32'd0);

    // Clear on the completion cycle: set must win
    run_frame("del_same_cycle", 8'h96, 1'b1, 10'b1_10010110_0, -1, 1'b1);

    // Reset in the middle of data bit 3 (flag is currently set)
    bus.tx_data    = 8'hA5;
    bus.baudselect = 1'b1;
    bus.start      = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    repeat (4 * DIV_HI + 100) @(negedge clk);
    check("pre_reset tx_bit3", 32'(bus.tx), 32'd0);
    check("pre_reset busy", 32'(bus.busy), 32'd1);
    reset_n = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    check("mid_reset tx", 32'(bus.tx), 32'd1);
    check("mid_reset busy", 32'(bus.busy), 32'd0);
    check("mid_reset flag", 32'(bus.tx_complete_flag), 32'd0);
    errs = 0;
    for (int i = 0; i < DIV_HI + 10; i++) begin
      if (bus.tx !== 1'b1 || bus.busy !== 1'b0) errs++;
      @(negedge clk);
    end
    check("abandoned_frame bad_cycles", 32'(errs), 32'd0);
    run_frame("after_reset", 8'h5A, 1'b1, 10'b1_01011010_0, -1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
